// File: rtl/qsfp_i2c_seq.sv
// Wishbone master sequencer: initialises an I2C master core once, then performs one QSFP register read per start.
// Optional poll timeout is compiled in when QSFP_SEQ_TIMEOUT_EN is defined.
module qsfp_i2c_seq #(
  parameter logic [15:0] PRESCALE       = 16'd49,
  parameter logic [6:0]  DEV_ADDR       = 7'h50,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_ni,
  input  logic       start_i,
  input  logic [7:0] reg_addr_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  output logic [7:0] rdata_o,
  output logic [2:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  output logic       wbm_we_o,
  output logic       wbm_cyc_o,
  output logic       wbm_stb_o,
  input  logic [7:0] wbm_dat_i,
  input  logic       wbm_ack_i
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;
  typedef enum logic [1:0] {OP_WR, OP_POLL, OP_RD} op_e;

  localparam logic [4:0] STEP_INIT_LAST  = 5'd2;
  localparam logic [4:0] STEP_TXN        = 5'd3;
  localparam logic [4:0] STEP_ABORT      = 5'd15;
  localparam logic [4:0] STEP_ABORT_POLL = 5'd16;

  state_e     state_q, state_d;
  logic [4:0] step_q, step_d;
  logic [7:0] raddr_q, raddr_d;
  logic       init_done_q, init_done_d;
  logic       busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic       cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [2:0] adr_q, adr_d;
  logic [7:0] dat_q, dat_d;
  logic [1:0] rst_sync_q;
  logic       run, tmo, ackchk, fin, fin_err;
  op_e        op;
  logic [2:0] op_adr;
  logic [7:0] op_dat;

  // Reset release is re-timed so the FSM never starts on a metastable deassertion.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) rst_sync_q <= 2'b00;
    else            rst_sync_q <= {rst_sync_q[0], 1'b1};
  assign run = rst_sync_q[1];

  // Micro-program: one step per bus access kind; POLL steps repeat until TIP clears.
  always_comb begin
    op = OP_WR; op_adr = 3'd4; op_dat = 8'h00; ackchk = 1'b0;
    case (step_q)
      5'd0:  begin op_adr = 3'd0; op_dat = PRESCALE[7:0];  end
      5'd1:  begin op_adr = 3'd1; op_dat = PRESCALE[15:8]; end
      5'd2:  begin op_adr = 3'd2; op_dat = 8'h80;          end
      5'd3:  begin op_adr = 3'd3; op_dat = {DEV_ADDR, 1'b0}; end
      5'd4:  op_dat = 8'h90;
      5'd5:  begin op = OP_POLL; ackchk = 1'b1; end
      5'd6:  begin op_adr = 3'd3; op_dat = raddr_q; end
      5'd7:  op_dat = 8'h10;
      5'd8:  begin op = OP_POLL; ackchk = 1'b1; end
      5'd9:  begin op_adr = 3'd3; op_dat = {DEV_ADDR, 1'b1}; end
      5'd10: op_dat = 8'h90;
      5'd11: begin op = OP_POLL; ackchk = 1'b1; end
      5'd12: op_dat = 8'h68;
      5'd13: op = OP_POLL;
      5'd14: begin op = OP_RD; op_adr = 3'd3; end
      5'd15: op_dat = 8'h40;
      5'd16: op = OP_POLL;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q; step_d = step_q; raddr_d = raddr_q; init_done_d = init_done_q;
    busy_d = busy_q; done_d = 1'b0; err_d = 1'b0; rdata_d = rdata_q;
    cyc_d = cyc_q; stb_d = stb_q; we_d = we_q; adr_d = adr_q; dat_d = dat_q;
    fin = 1'b0; fin_err = 1'b0;
    case (state_q)
      S_IDLE:
        if (run && start_i) begin
          raddr_d = reg_addr_i;
          step_d  = init_done_q ? STEP_TXN : 5'd0;
          busy_d  = 1'b1;
          state_d = S_ISSUE;
        end
      S_ISSUE:
        if (op == OP_POLL && tmo) begin
          fin = 1'b1; fin_err = 1'b1;
        end else begin
          cyc_d = 1'b1; stb_d = 1'b1; we_d = (op == OP_WR);
          adr_d = op_adr; dat_d = (op == OP_WR) ? op_dat : 8'h00;
          state_d = S_WAIT;
        end
      S_WAIT:
        if (wbm_ack_i) begin
          // ISSUE doubles as the idle gap, so strobes are never back-to-back.
          cyc_d = 1'b0; stb_d = 1'b0; we_d = 1'b0; state_d = S_ISSUE;
          case (op)
            OP_WR: begin
              step_d = step_q + 5'd1;
              if (step_q == STEP_INIT_LAST) init_done_d = 1'b1;
            end
            OP_POLL:
              if (tmo) begin fin = 1'b1; fin_err = 1'b1; end
              else if (wbm_dat_i[1]) begin end
              else if (ackchk && wbm_dat_i[7]) step_d = STEP_ABORT;
              else if (step_q == STEP_ABORT_POLL) begin fin = 1'b1; fin_err = 1'b1; end
              else step_d = step_q + 5'd1;
            OP_RD: begin rdata_d = wbm_dat_i; fin = 1'b1; end
            default: ;
          endcase
        end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      state_d = S_IDLE; busy_d = 1'b0; done_d = 1'b1; err_d = fin_err;
    end
  end

`ifdef QSFP_SEQ_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  assign tmo = (tmo_cnt_q >= TIMEOUT_CYCLES);
  always_comb begin
    tmo_cnt_d = 32'd0;
    if (state_q != S_IDLE && step_d == step_q && op == OP_POLL) tmo_cnt_d = tmo_cnt_q + 32'd1;
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) tmo_cnt_q <= 32'd0;
    else            tmo_cnt_q <= tmo_cnt_d;
`else
  // Without the feature the limit has no effect.
  assign tmo = (TIMEOUT_CYCLES == 32'd0) & 1'b0;
`endif

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni)
    if (!wb_rst_ni) begin
      state_q <= S_IDLE; step_q <= 5'd0; raddr_q <= 8'h00; init_done_q <= 1'b0;
      busy_q <= 1'b0; done_q <= 1'b0; err_q <= 1'b0; rdata_q <= 8'h00;
      cyc_q <= 1'b0; stb_q <= 1'b0; we_q <= 1'b0; adr_q <= 3'd0; dat_q <= 8'h00;
    end else begin
      state_q <= state_d; step_q <= step_d; raddr_q <= raddr_d; init_done_q <= init_done_d;
      busy_q <= busy_d; done_q <= done_d; err_q <= err_d; rdata_q <= rdata_d;
      cyc_q <= cyc_d; stb_q <= stb_d; we_q <= we_d; adr_q <= adr_d; dat_q <= dat_d;
    end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_we_o  = we_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
endmodule

// File: doc/qsfp_i2c_seq.md
QSFP_I2C_SEQ -- requirements
Module: qsfp_i2c_seq

Interface
REQ-001 SHALL have parameter PRESCALE, default 16'd49, value programmed into the I2C core PRER (PRESCALE[7:0] to addr 0, PRESCALE[15:8] to addr 1).
REQ-002 SHALL have parameter DEV_ADDR, default 7'h50, 7-bit QSFP slave address.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 32'd100000, poll limit in clock cycles (used only under REQ-028).
REQ-004 wb_clk_i  in  1  system clock; all logic rising-edge.
REQ-005 wb_rst_ni  in  1  asynchronous active-low reset.
REQ-006 start_i  in  1  request one read transaction; sampled only when busy_o=0.
REQ-007 reg_addr_i  in  8  QSFP register index; captured on the accepted start_i.
REQ-008 busy_o  out  1  high from the cycle after start acceptance until the return to IDLE.
REQ-009 done_o  out  1  one-cycle completion pulse.
REQ-010 err_o  out  1  valid with done_o; 1 = NACK or timeout.
REQ-011 rdata_o  out  8  read byte; updated only on successful completion.
REQ-012 wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_cyc_o, wbm_stb_o  out  3/8/1/1/1  Wishbone B3 classic master to the I2C core.
REQ-013 wbm_dat_i, wbm_ack_i  in  8/1  Wishbone slave response.

Function
REQ-014 Each bus access SHALL assert cyc/stb with a stable adr/dat/we, hold until ack, and drop cyc/stb in the cycle after ack; there SHALL be no back-to-back strobes and no cti/bte bursts.
REQ-015 After the first start following reset, the block SHALL run INIT once: write PRER_LO, then PRER_HI, then CTR=0x80. An init_done flag SHALL skip INIT on later starts.
REQ-016 Transaction sequence; each step is a register write followed, where marked, by POLL:
- TXR=DEV_ADDR<<1|0; CR=0x90; POLL; ACKCHK
- TXR=reg_addr; CR=0x10; POLL; ACKCHK
- TXR=DEV_ADDR<<1|1; CR=0x90; POLL; ACKCHK
- CR=0x68 (RD, NACK, STO); POLL; read RXR (addr 3) into rdata_o
- DONE
REQ-017 POLL SHALL read SR (addr 4) repeatedly and exit when SR[1] (TIP) = 0.
REQ-018 ACKCHK SHALL proceed when SR[7] (RxACK) = 0 as sampled in the final POLL read. If SR[7] = 1 it SHALL enter ABORT: write CR=0x40, POLL, then DONE with err_o=1.
REQ-019 DONE SHALL pulse done_o for exactly one cycle in the first cycle back in IDLE, with busy_o=0 in that cycle.
REQ-020 A start_i in the done_o cycle SHALL be accepted.
REQ-021 start_i while busy_o=1 SHALL be ignored; no queuing.
REQ-022 rdata_o SHALL hold its previous value on an error completion.
REQ-023 wbm_dat_i SHALL be sampled only in ack cycles.

Reset
REQ-024 Asserting wb_rst_ni SHALL immediately and asynchronously force: state=IDLE, init_done=0, busy_o=0, done_o=0, err_o=0, rdata_o=8'h00, wbm_cyc_o=0, wbm_stb_o=0, wbm_we_o=0, wbm_adr_o=0, wbm_dat_o=0.
REQ-025 Reset mid-transaction SHALL abandon the bus cycle without STOP; the next start SHALL redo INIT.
REQ-026 Deassertion SHALL be synchronised internally (two-flop) before the FSM leaves reset.

Configuration
REQ-027 Macro QSFP_SEQ_TIMEOUT_EN SHALL gate the poll-timeout feature.
REQ-028 With QSFP_SEQ_TIMEOUT_EN defined: a 32-bit counter SHALL clear on POLL entry and increment every cycle in POLL. When it reaches TIMEOUT_CYCLES, the block SHALL finish any pending ack, then complete with done_o=1, err_o=1, with no STOP write.
REQ-029 Without QSFP_SEQ_TIMEOUT_EN: no counter, POLL waits indefinitely, and TIMEOUT_CYCLES is ignored.

Verification
REQ-030 Reset, then start_i with reg_addr_i=8'h94 and a model ACKing all bytes and returning 8'hA5 -> writes observed in order: 0:31, 1:00, 2:80, 3:A0, 4:90, 3:94, 4:10, 3:A1, 4:90, 4:68; then RXR is read; done_o pulses once, err_o=0, rdata_o=8'hA5.
REQ-031 A second start -> no PRER/CTR writes; the sequence begins at TXR=A0.
REQ-032 Model NACKs the device address (SR=8'h80 after TIP clears) -> CR=0x40 is written, done_o=1 with err_o=1, rdata_o unchanged.
REQ-033 wbm_ack_i delayed 5 cycles on every access, and start_i pulsed while busy -> ignored start has no effect; result equals REQ-030.
REQ-034 wb_rst_ni low during the second POLL -> all outputs at reset values in the same cycle; a following start re-runs INIT.
REQ-035 With QSFP_SEQ_TIMEOUT_EN defined, TIMEOUT_CYCLES=100 and TIP stuck at 1 -> done_o with err_o=1 within 100 cycles of POLL entry plus one access.
